memory_access_unit: RTL and testbench

Initiator-side controller for the byte-wide data memory. It accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the CPU execute/memory stage and serialises each request into one-byte accesses on the memory's write and read ports, using little-endian byte order. It assembles load results and applies sign or zero extension. Misaligned and illegal requests are rejected without touching memory.

---
 rtl/memory_access_unit.sv | 173 +++++++++++++++++
 tb/tb_memory_access_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// ============================================================================
// Module   : memory_access_unit
// Brief    : Serialises RV32I loads/stores into byte accesses on a byte-wide memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memory_access_unit #(
  parameter int ADDRW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_waddr,
  output logic [7:0]       mem_wdata,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [7:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_write;
  logic [2:0]       r_funct3;
  logic [ADDRW-1:0] r_base;
  logic [31:0]      r_wdata;
  logic [1:0]       r_nlast;
  logic [1:0]       r_cnt;
  logic [31:0]      r_acc;

  logic [1:0]       w_nlast;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_bad;
  logic             w_accept;
  logic             w_last;
  logic [ADDRW-1:0] w_addr;
  logic [31:0]      w_full;
  logic [31:0]      w_ext;
  logic             w_unused;

  assign w_unused = ^req_addr[31:ADDRW];

  always_comb begin
    w_nlast = 2'd0;
    case (req_funct3[1:0])
      2'b01:   w_nlast = 2'd1;
      2'b10:   w_nlast = 2'd3;
      default: w_nlast = 2'd0;
    endcase
  end

  assign w_illegal  = req_write ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                                   (req_funct3 == 3'b111));
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_bad      = w_illegal || w_misalign;
  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_last     = (r_cnt == r_nlast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bad)          w_next = S_ERR;
          else if (req_write) w_next = S_STORE;
          else                w_next = S_LOAD;
        end
      end
      S_STORE: if (w_last) w_next = S_RESP;
      S_LOAD:  if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_RESP;
      S_ERR:   w_next = S_IDLE;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Last byte of a load is still on mem_rdata during DRAIN; merge it in directly.
  always_comb begin
    w_full = r_acc;
    w_full[{r_nlast, 3'b000} +: 8] = mem_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_full[7]}}, w_full[7:0]};
      3'b001:  w_ext = {{16{w_full[15]}}, w_full[15:0]};
      3'b010:  w_ext = w_full;
      3'b100:  w_ext = {24'd0, w_full[7:0]};
      3'b101:  w_ext = {16'd0, w_full[15:0]};
      default: w_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_funct3   <= 3'd0;
      r_base     <= '0;
      r_wdata    <= 32'd0;
      r_nlast    <= 2'd0;
      r_cnt      <= 2'd0;
      r_acc      <= 32'd0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_base   <= req_addr[ADDRW-1:0];
            r_wdata  <= req_wdata;
            r_nlast  <= w_nlast;
            r_cnt    <= 2'd0;
            if (w_bad) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end
          end
        end
        S_STORE: begin
          r_cnt <= r_cnt + 2'd1;
          if (w_last) resp_err <= 1'b0;
        end
        S_LOAD: begin
          r_cnt <= r_cnt + 2'd1;
          // Read data lags the address by one cycle.
          if (r_cnt != 2'd0) r_acc[{r_cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
        end
        S_DRAIN: begin
          resp_rdata <= w_ext;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_addr     = r_base + ADDRW'(r_cnt);
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
  assign mem_we     = (r_state == S_STORE);
  assign mem_waddr  = w_addr;
  assign mem_raddr  = w_addr;
  assign mem_wdata  = r_wdata[{r_cnt, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: tb/tb_memory_access_unit.sv
// ============================================================================
// Module   : tb_memory_access_unit
// Brief    : Scoreboard bench for memory_access_unit with a byte memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_memory_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_raddr;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:255];

  typedef struct {
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  exp_t sb[$];
  wr_t  wr_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  memory_access_unit #(.ADDRW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
    int   n;
    int   lat;
    int   w;
    bit   seen;
    exp_t e;
    wr_t  wx;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lat = exp_err ? 1 : (wr ? n + 1 : n + 2);
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) check({name, ".ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    e.err = exp_err; e.is_load = !wr; e.rdata = exp_rd; e.lat = lat;
    sb.push_back(e);
    if (wr && !exp_err)
      for (int i = 0; i < n; i++) begin
        wx.addr = addr[7:0] + 8'(i);
        wx.data = wd[8*i +: 8];
        wx.cyc  = i + 1;
        wr_q.push_back(wx);
      end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_we) begin
        if (wr_q.size() == 0) check({name, ".unexp_we"}, 32'(mem_we), 32'd0);
        else begin
          wx = wr_q.pop_front();
          check($sformatf("%s.waddr%0d", name, k), 32'(mem_waddr), 32'(wx.addr));
          check($sformatf("%s.wdata%0d", name, k), 32'(mem_wdata), 32'(wx.data));
          check($sformatf("%s.wcyc%0d", name, k), 32'(k), 32'(wx.cyc));
        end
      end
      if (!wr && !exp_err && k <= n)
        check($sformatf("%s.raddr%0d", name, k), 32'(mem_raddr), 32'(addr[7:0] + 8'(k - 1)));
      if (resp_valid) begin
        seen = 1;
        if (sb.size() == 0) check({name, ".unexp_resp"}, 32'(resp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          check({name, ".lat"}, 32'(k), 32'(e.lat));
          check({name, ".err"}, 32'(resp_err), 32'(e.err));
          if (e.is_load || e.err) check({name, ".rdata"}, resp_rdata, e.rdata);
          check({name, ".ready_busy"}, 32'(req_ready), 32'd0);
        end
      end
    end
    if (!seen) check({name, ".resp_timeout"}, 32'(seen), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst.mem_raddr", 32'(mem_raddr), 32'd0);

    do_req("sw10",   1'b1, 3'b010, 32'h10,  32'hA1B2C3D4, 1'b0, 32'h0);
    do_req("lw10",   1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hA1B2C3D4);
    do_req("lb13",   1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFFA1);
    do_req("lbu13",  1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h000000A1);
    do_req("lh12",   1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFFA1B2);
    do_req("lhu12",  1'b0, 3'b101, 32'h12,  32'h0,        1'b0, 32'h0000A1B2);
    do_req("lh10",   1'b0, 3'b001, 32'h10,  32'h0,        1'b0, 32'hFFFFC3D4);
    do_req("lb10",   1'b0, 3'b000, 32'h10,  32'h0,        1'b0, 32'hFFFFFFD4);
    do_req("lw11",   1'b0, 3'b010, 32'h11,  32'h0,        1'b1, 32'h0);
    do_req("sh03",   1'b1, 3'b001, 32'h03,  32'hFFFF,     1'b1, 32'h0);
    do_req("ld011",  1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0);
    do_req("lhu12b", 1'b0, 3'b101, 32'h12,  32'h0,        1'b0, 32'h0000A1B2);
    do_req("ld110",  1'b0, 3'b110, 32'h10,  32'h0,        1'b1, 32'h0);
    do_req("st100",  1'b1, 3'b100, 32'h10,  32'h12345678, 1'b1, 32'h0);
    do_req("sb1ff",  1'b1, 3'b000, 32'h1FF, 32'h55,       1'b0, 32'h0);
    do_req("lbuff",  1'b0, 3'b100, 32'hFF,  32'h0,        1'b0, 32'h00000055);
    do_req("sh40",   1'b1, 3'b001, 32'h40,  32'h0000807F, 1'b0, 32'h0);
    do_req("lh40",   1'b0, 3'b001, 32'h40,  32'h0,        1'b0, 32'hFFFF807F);
    check("mem.10", 32'(mem[8'h10]), 32'hD4);
    check("mem.13", 32'(mem[8'h13]), 32'hA1);
    check("mem.ff", 32'(mem[8'hFF]), 32'h55);

    // Abort an SW to 0x20 after its first two bytes have been written.
    @(negedge clk);
    check("abort.pre_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.mem_we", 32'(mem_we), 32'd0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.mem_waddr", 32'(mem_waddr), 32'd0);
    check("abort.mem_wdata", 32'(mem_wdata), 32'd0);
    check("abort.resp_rdata", resp_rdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort.rst_valid", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort.post_ready", 32'(req_ready), 32'd1);
      check("abort.post_valid", 32'(resp_valid), 32'd0);
      check("abort.post_we", 32'(mem_we), 32'd0);
    end
    check("abort.mem20", 32'(mem[8'h20]), 32'h44);
    check("abort.mem21", 32'(mem[8'h21]), 32'h33);
    check("abort.mem22", 32'(mem[8'h22]), 32'h00);
    check("abort.mem23", 32'(mem[8'h23]), 32'h00);

    do_req("lw10r",  1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hA1B2C3D4);
    do_req("lh20",   1'b0, 3'b001, 32'h20,  32'h0,        1'b0, 32'h00003344);

    check("sb.empty", 32'(sb.size()), 32'd0);
    check("wrq.empty", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
